fsmc_wave_fifo: RTL and testbench

Register-mapped sample FIFO directly downstream of `fsmc_interface`. It consumes the MCU write data, chip-select code and transaction state decoded from the FSMC multiplexed AD bus. Writes to the data channel are buffered in a DEPTH-entry FIFO, and the buffered samples are streamed to a consumer such as a DAC driver over a valid/ready handshake. The block also supplies read-back data (status, level, control) that `fsmc_interface` returns to the MCU on NOE cycles.

---
 rtl/fsmc_wave_fifo.sv | 146 ++++++++++++++
 tb/tb_fsmc_wave_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_wave_fifo.sv
// fsmc_wave_fifo
// Register-mapped sample FIFO sitting behind fsmc_interface. MCU writes to the
// data code are buffered and streamed out over valid/ready (first-word
// fall-through). The control, status and level registers are muxed back onto
// fsmc_tx_data for MCU reads.
module fsmc_wave_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          DW        = 16,
  parameter int          LOW_WATER = 4,
  parameter logic [3:0]  CS_DATA   = 4'd0,
  parameter logic [3:0]  CS_CTRL   = 4'd1,
  parameter logic [3:0]  CS_STAT   = 4'd2,
  parameter logic [3:0]  CS_LEVEL  = 4'd3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    fsmc_cs,
  input  logic          fsmc_state,
  input  logic [DW-1:0] fsmc_rx_data,
  output logic [DW-1:0] fsmc_tx_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Registered state
  logic          state_q,  state_d;   // previous-cycle fsmc_state
  logic          armed_q,  armed_d;   // fsmc_state seen low since reset
  logic          en_q,     en_d;
  logic          ovf_q,    ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          irq_q,    irq_d;
  logic [DW-1:0] tx_q,     tx_d;

  logic [DW-1:0] mem [DEPTH];

  // Decoded strobes
  logic wr_stb, push, ctrl_wr, flush, clr_ovf;
  logic empty, full, pop, push_ok, overflow;

  // A write still in progress when reset releases must not commit, so the
  // edge detector is only armed once fsmc_state has been observed low.
  assign wr_stb   = fsmc_state & ~state_q & armed_q;
  assign push     = wr_stb & (fsmc_cs == CS_DATA);
  assign ctrl_wr  = wr_stb & (fsmc_cs == CS_CTRL);
  assign flush    = ctrl_wr & fsmc_rx_data[1];
  assign clr_ovf  = ctrl_wr & fsmc_rx_data[2];

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  // Flush wins over a same-cycle pop; a full FIFO still accepts a push when
  // a pop frees the slot in the same cycle.
  assign out_valid = en_q & ~empty;
  assign pop       = out_valid & out_ready & ~flush;
  assign push_ok   = push & (~full | pop);
  assign overflow  = push & full & ~pop;

  assign out_data     = out_valid ? mem[rd_ptr_q] : '0;
  assign fsmc_tx_data = tx_q;
  assign irq          = irq_q;

  // Next-state logic for control, pointers, level, interrupt and read-back
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d  = fsmc_state;
    armed_d  = armed_q | ~fsmc_state;
    en_d     = en_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tx_d     = '0;

    if (ctrl_wr) en_d = fsmc_rx_data[0];

    // Clear first so a same-cycle overflow overrides it.
    if (clr_ovf)  ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    irq_d = en_q & (int'(count_q) < LOW_WATER);

    case (fsmc_cs)
      CS_CTRL:  tx_d = DW'(en_q);
      CS_STAT:  tx_d = DW'({en_q, ovf_q, full, empty});
      CS_LEVEL: tx_d = DW'(count_q);
      default:  tx_d = '0;
    endcase
  end

  // State registers with synchronous reset; reset overrides every strobe
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the same pre-edge values.
    if (reset) begin
      state_q  <= 1'b0;
      armed_q  <= 1'b0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      tx_q     <= tx_d;
    end
  end

  // Sample storage written on accepted pushes
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately not reset; pointers and count define
    // which entries are valid, and this lets it map onto block memory.
    if (push_ok && !reset) mem[wr_ptr_q] <= fsmc_rx_data;
  end

endmodule

// File: tb/tb_fsmc_wave_fifo.sv
// Self-checking bench for fsmc_wave_fifo: a queue-based reference model is
// updated as bus writes commit, and a monitor compares every stream handshake
// against the head of that queue.
module tb_fsmc_wave_fifo;

  localparam int         DEPTH     = 16;
  localparam int         DW        = 16;
  localparam int         LOW_WATER = 4;
  localparam logic [3:0] CS_DATA   = 4'd0;
  localparam logic [3:0] CS_CTRL   = 4'd1;
  localparam logic [3:0] CS_STAT   = 4'd2;
  localparam logic [3:0] CS_LEVEL  = 4'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    fsmc_cs;
  logic          fsmc_state;
  logic [DW-1:0] fsmc_rx_data;
  logic [DW-1:0] fsmc_tx_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          irq;

  fsmc_wave_fifo #(
    .DEPTH(DEPTH), .DW(DW), .LOW_WATER(LOW_WATER),
    .CS_DATA(CS_DATA), .CS_CTRL(CS_CTRL), .CS_STAT(CS_STAT), .CS_LEVEL(CS_LEVEL)
  ) dut (
    .clk(clk), .reset(reset), .fsmc_cs(fsmc_cs), .fsmc_state(fsmc_state),
    .fsmc_rx_data(fsmc_rx_data), .fsmc_tx_data(fsmc_tx_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queued samples, enable and sticky overflow
  logic [DW-1:0] exp_q[$];
  logic          en_m  = 1'b0;
  logic          ovf_m = 1'b0;
  logic          rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Apply the effect of a write committed in the current cycle
  task automatic model_commit(input logic [3:0] cs, input logic [DW-1:0] data);
    bit pop_now;
    if (cs == CS_DATA) begin
      pop_now = en_m && out_ready && (exp_q.size() > 0);
      if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(data);
      else ovf_m = 1'b1;
    end else if (cs == CS_CTRL) begin
      if (data[1]) exp_q.delete();
      if (data[2]) ovf_m = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [3:0] cs, input logic [DW-1:0] data, input int hold);
    tick();
    fsmc_cs      = cs;
    fsmc_rx_data = data;
    fsmc_state   = 1'b1;
    model_commit(cs, data);
    tick();
    if (cs == CS_CTRL) en_m = data[0];
    repeat (hold - 1) tick();
    fsmc_state = 1'b0;
  endtask

  task automatic read_reg(input string name, input logic [3:0] cs, input logic [DW-1:0] exp);
    tick();
    fsmc_cs = cs;
    tick();
    check(name, 32'(fsmc_tx_data), 32'(exp));
  endtask

  function automatic logic [DW-1:0] exp_stat();
    return DW'({en_m, ovf_m, exp_q.size() == DEPTH, exp_q.size() == 0});
  endfunction

  // Status, level and irq against the model while the FIFO is not moving
  task automatic check_idle(input string tag);
    read_reg({tag, "_stat"}, CS_STAT, exp_stat());
    read_reg({tag, "_level"}, CS_LEVEL, DW'(exp_q.size()));
    check({tag, "_irq"}, 32'(irq), 32'(en_m && (exp_q.size() < LOW_WATER)));
  endtask

  // Monitor: every handshake must match the oldest expected sample
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) begin
        if (out_data !== '0) check("idle_data_zero", 32'(out_data), 32'h0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
        else check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    fsmc_cs      = 4'd0;
    fsmc_state   = 1'b0;
    fsmc_rx_data = '0;
    out_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset defaults
    read_reg("rst_stat", CS_STAT, 16'h0001);
    read_reg("rst_level", CS_LEVEL, 16'h0000);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Push two samples, then enable with a ready consumer
    bus_write(CS_DATA, 16'h0F0F, 10);
    bus_write(CS_DATA, 16'h1234, 10);
    read_reg("two_level", CS_LEVEL, 16'h0002);
    out_ready = 1'b1;
    bus_write(CS_CTRL, 16'h0001, 1);
    check("first_out_valid", 32'(out_valid), 32'h1);
    check("first_out_data", 32'(out_data), 32'h0F0F);
    tick();
    check("second_out_data", 32'(out_data), 32'h1234);
    tick();
    out_ready = 1'b0;
    read_reg("drained_level", CS_LEVEL, 16'h0000);
    check("drained_irq", 32'(irq), 32'h1);

    // Overflow with the stream disabled
    bus_write(CS_CTRL, 16'h0000, 2);
    for (int i = 0; i < DEPTH + 1; i++) bus_write(CS_DATA, DW'(16'hA000 + i), 2);
    read_reg("ovf_stat", CS_STAT, 16'h0006);
    read_reg("ovf_level", CS_LEVEL, 16'd16);
    bus_write(CS_CTRL, 16'h0004, 2);
    read_reg("clr_ovf_stat", CS_STAT, 16'h0002);

    // Full FIFO, enabled: push lands in the same cycle as the first pop
    bus_write(CS_CTRL, 16'h0001, 2);
    tick();
    out_ready    = 1'b1;
    fsmc_cs      = CS_DATA;
    fsmc_rx_data = 16'hBEEF;
    fsmc_state   = 1'b1;
    model_commit(CS_DATA, 16'hBEEF);
    tick();
    out_ready  = 1'b0;
    fsmc_state = 1'b0;
    read_reg("concur_level", CS_LEVEL, 16'd16);
    read_reg("concur_stat", CS_STAT, 16'h000A);
    out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    out_ready = 1'b0;
    check_idle("concur_drain");

    // Flush after five pushes
    bus_write(CS_CTRL, 16'h0000, 2);
    for (int i = 0; i < 5; i++) bus_write(CS_DATA, DW'($urandom), 2);
    bus_write(CS_CTRL, 16'h0003, 1);
    check("flush_valid", 32'(out_valid), 32'h0);
    read_reg("flush_level", CS_LEVEL, 16'h0000);
    read_reg("flush_ctrl", CS_CTRL, 16'h0001);

    // Long strobe commits once; non-data codes change nothing
    bus_write(CS_DATA, 16'h5A5A, 20);
    read_reg("long_level", CS_LEVEL, 16'h0001);
    bus_write(CS_STAT, 16'hFFFF, 3);
    bus_write(4'd9, 16'hFFFF, 3);
    read_reg("nondata_stat", CS_STAT, 16'h0008);
    read_reg("nondata_level", CS_LEVEL, 16'h0001);
    read_reg("nondata_ctrl", CS_CTRL, 16'h0001);

    // Randomized traffic with a randomly stalling consumer
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0)
        bus_write(CS_CTRL, DW'({$urandom_range(0, 1), 1'b0, $urandom_range(0, 3) != 0}), 1);
      else
        bus_write(CS_DATA, DW'($urandom), $urandom_range(1, 3));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    bus_write(CS_CTRL, 16'h0001, 1);
    repeat (DEPTH + 8) tick();
    out_ready = 1'b0;
    check("rand_all_delivered", 32'(exp_q.size()), 32'h0);
    check_idle("rand_end");

    // Reset while a sample is presented
    for (int i = 0; i < 2; i++) bus_write(CS_DATA, DW'(16'hC000 + i), 1);
    fsmc_cs = CS_STAT;
    tick();
    check("pre_reset_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_tx", 32'(fsmc_tx_data), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    exp_q.delete();
    en_m  = 1'b0;
    ovf_m = 1'b0;
    check_idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
